// File: rtl/adc_stim_pkg.sv
// Shared types and constants for the ADC stimulus generator.
//   mode_t    : waveform select (constant, ramp, triangle, LFSR)
//   state_t   : run-control FSM states
//   LFSR_TAPS : tap mask for x^16+x^14+x^13+x^11+1, left-shifting Fibonacci form
//   lfsr_next : one LFSR step
package adc_stim_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_TRI   = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Shift left; the new LSB is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/adc_stim_gen_if.sv
// Control and sample bus of the ADC stimulus generator.
//   i_en      : run enable
//   i_mode    : waveform select (see adc_stim_pkg::mode_t)
//   i_div     : sample period minus one, in clocks
//   i_const   : value emitted in constant mode
//   o_data    : packed samples, channel ch at [ch*DATA_W +: DATA_W]
//   o_valid   : one-cycle strobe marking a new o_data
// master = stimulus/control side, slave = generator.
interface adc_stim_gen_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 16
);
    logic                     i_en;
    logic [1:0]               i_mode;
    logic [DIV_W-1:0]         i_div;
    logic [DATA_W-1:0]        i_const;
    logic [NUM_CH*DATA_W-1:0] o_data;
    logic                     o_valid;

    modport master (output i_en, i_mode, i_div, i_const, input o_data, o_valid);
    modport slave  (input i_en, i_mode, i_div, i_const, output o_data, o_valid);
endinterface

// File: rtl/adc_stim_chan.sv
// One generator channel: ramp/triangle counter, direction bit and LFSR.
//   i_clk, i_rst : clock, synchronous active-low reset
//   i_tick       : emit a sample and advance the active generator
//   i_reinit     : with i_tick, restart all generators from their initial values
//   i_mode       : active waveform
//   i_const      : constant-mode value
//   i_ch         : channel index (offsets counter start and LFSR seed)
//   o_sample     : registered sample
module adc_stim_chan
    import adc_stim_pkg::*;
#(
    parameter int unsigned DATA_W    = 14,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tick,
    input  logic              i_reinit,
    input  mode_t             i_mode,
    input  logic [DATA_W-1:0] i_const,
    input  logic [2:0]        i_ch,
    output logic [DATA_W-1:0] o_sample
);
    localparam logic [DATA_W-1:0] MAX = '1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] init_cnt, cnt_q, cnt_d, cur_cnt, sample_q, sample_d;
    logic [15:0]       init_lfsr, lfsr_q, lfsr_d, cur_lfsr;
    logic              up_q, up_d, cur_up;

    assign init_cnt  = DATA_W'(i_ch);
    assign init_lfsr = LFSR_SEED ^ {13'd0, i_ch};

    // Reinit takes effect in the same tick, so that tick emits initial values.
    assign cur_cnt  = i_reinit ? init_cnt  : cnt_q;
    assign cur_up   = i_reinit ? 1'b1      : up_q;
    assign cur_lfsr = i_reinit ? init_lfsr : lfsr_q;

    always_comb begin
        cnt_d    = cnt_q;
        up_d     = up_q;
        lfsr_d   = lfsr_q;
        sample_d = sample_q;
        if (i_tick) begin
            cnt_d  = cur_cnt;
            up_d   = cur_up;
            lfsr_d = cur_lfsr;
            unique case (i_mode)
                MODE_CONST: sample_d = i_const;
                MODE_RAMP: begin
                    sample_d = cur_cnt;
                    cnt_d    = cur_cnt + ONE;
                end
                MODE_TRI: begin
                    sample_d = cur_cnt;
                    // Turn around on the endpoint itself so it is emitted once.
                    if (cur_up) begin
                        if (cur_cnt == MAX) begin
                            up_d  = 1'b0;
                            cnt_d = cur_cnt - ONE;
                        end else begin
                            cnt_d = cur_cnt + ONE;
                        end
                    end else begin
                        if (cur_cnt == '0) begin
                            up_d  = 1'b1;
                            cnt_d = cur_cnt + ONE;
                        end else begin
                            cnt_d = cur_cnt - ONE;
                        end
                    end
                end
                MODE_LFSR: begin
                    sample_d = cur_lfsr[DATA_W-1:0];
                    lfsr_d   = lfsr_next(cur_lfsr);
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q    <= init_cnt;
            up_q     <= 1'b1;
            lfsr_q   <= init_lfsr;
            sample_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            up_q     <= up_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
        end
    end

    assign o_sample = sample_q;

endmodule

// File: rtl/adc_stim_gen.sv
// Multi-channel ADC stimulus generator top: run FSM, sample-rate divider,
// mode-change detection and NUM_CH generator channels.
//   i_clk : sole clock
//   i_rst : synchronous active-low reset
//   bus   : control inputs and sample outputs (adc_stim_gen_if.slave)
module adc_stim_gen
    import adc_stim_pkg::*;
#(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DIV_W     = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    adc_stim_gen_if.slave  bus
);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    state_t                   state_q, state_d;
    logic [DIV_W-1:0]         cnt_q, cnt_d;
    mode_t                    mode_q, mode_in;
    logic                     valid_q;
    logic                     tick, reinit;
    logic [NUM_CH*DATA_W-1:0] data;

    assign mode_in = mode_t'(bus.i_mode);

    // >= rather than == so lowering i_div below the count ticks at once.
    assign tick   = (state_q == ST_RUN) && bus.i_en && (cnt_q >= bus.i_div);
    assign reinit = tick && (mode_in != mode_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: if (bus.i_en)  state_d = ST_RUN;
            ST_RUN:  if (!bus.i_en) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Counter is zero whenever not running, which also covers entry to RUN.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_RUN) && bus.i_en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            mode_q  <= MODE_CONST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= tick;
            if (tick) begin
                mode_q <= mode_in;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        adc_stim_chan #(
            .DATA_W    (DATA_W),
            .LFSR_SEED (LFSR_SEED)
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (tick),
            .i_reinit (reinit),
            .i_mode   (mode_in),
            .i_const  (bus.i_const),
            .i_ch     (3'(ch)),
            .o_sample (data[ch*DATA_W +: DATA_W])
        );
    end

    assign bus.o_data  = data;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_adc_stim_gen.sv
module tb_adc_stim_gen;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    adc_stim_gen_if #(.DATA_W(14), .NUM_CH(4), .DIV_W(16)) bus ();
    adc_stim_gen_if #(.DATA_W(4),  .NUM_CH(1), .DIV_W(16)) bus4 ();

    adc_stim_gen #(.DATA_W(14), .NUM_CH(4), .DIV_W(16), .LFSR_SEED(16'hACE1)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    adc_stim_gen #(.DATA_W(4), .NUM_CH(1), .DIV_W(16), .LFSR_SEED(16'hACE1)) dut4 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus4)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [55:0] pack4(input int a, input int b, input int c, input int d);
        logic [13:0] va, vb, vc, vd;
        va = 14'(a); vb = 14'(b); vc = 14'(c); vd = 14'(d);
        return {vd, vc, vb, va};
    endfunction

    function automatic logic [13:0] ch0();
        return bus.o_data[13:0];
    endfunction

    initial begin
        logic [15:0] ref_st [4];
        logic [55:0] exp_w;
        int          r0;
        int          tv;

        i_rst         = 1'b0;
        bus.i_en      = 1'b1;
        bus.i_mode    = 2'd1;
        bus.i_div     = 16'd0;
        bus.i_const   = 14'd0;
        bus4.i_en     = 1'b0;
        bus4.i_mode   = 2'd2;
        bus4.i_div    = 16'd0;
        bus4.i_const  = 4'd0;

        step();
        step();
        chk("reset_data", 64'(bus.o_data), 64'd0);
        chk("reset_valid", 64'(bus.o_valid), 64'd0);

        // Reset release: INIT, IDLE, then first tick on edge 3.
        i_rst = 1'b1;
        step();
        chk("edge1_valid", 64'(bus.o_valid), 64'd0);
        step();
        chk("edge2_valid", 64'(bus.o_valid), 64'd0);
        step();
        chk("edge3_valid", 64'(bus.o_valid), 64'd1);
        chk("ramp_first", 64'(bus.o_data), 64'(pack4(0, 1, 2, 3)));
        step();
        chk("ramp_second_valid", 64'(bus.o_valid), 64'd1);
        chk("ramp_second", 64'(bus.o_data), 64'(pack4(1, 2, 3, 4)));

        // Pause for 10 cycles: output held, no strobe.
        bus.i_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_valid", 64'(bus.o_valid), 64'd0);
            chk("pause_hold", 64'(bus.o_data), 64'(pack4(1, 2, 3, 4)));
        end
        bus.i_en = 1'b1;
        step();
        chk("resume_idle_valid", 64'(bus.o_valid), 64'd0);
        step();
        chk("resume_valid", 64'(bus.o_valid), 64'd1);
        chk("resume_data", 64'(bus.o_data), 64'(pack4(2, 3, 4, 5)));

        // Mode switch to constant and back to ramp.
        bus.i_mode  = 2'd0;
        bus.i_const = 14'h1234;
        step();
        chk("const_data", 64'(bus.o_data), 64'(pack4('h1234, 'h1234, 'h1234, 'h1234)));
        bus.i_mode = 2'd1;
        step();
        chk("ramp_reinit", 64'(bus.o_data), 64'(pack4(0, 1, 2, 3)));
        step();
        chk("ramp_after_reinit", 64'(bus.o_data), 64'(pack4(1, 2, 3, 4)));
        r0 = 2;

        // Divider 4: one strobe every 5 clocks.
        bus.i_div = 16'd4;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                chk("div4_gap", 64'(bus.o_valid), 64'd0);
            end
            step();
            chk("div4_tick", 64'(bus.o_valid), 64'd1);
            chk("div4_ch0", 64'(ch0()), 64'(r0));
            r0++;
        end

        // Divider 9, lowered to 2 at count 6: immediate tick, then period 3.
        bus.i_div = 16'd9;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("div9_gap", 64'(bus.o_valid), 64'd0);
        end
        bus.i_div = 16'd2;
        step();
        chk("div_lower_tick", 64'(bus.o_valid), 64'd1);
        chk("div_lower_ch0", 64'(ch0()), 64'(r0));
        r0++;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) begin
                step();
                chk("div2_gap", 64'(bus.o_valid), 64'd0);
            end
            step();
            chk("div2_tick", 64'(bus.o_valid), 64'd1);
            chk("div2_ch0", 64'(ch0()), 64'(r0));
            r0++;
        end

        // LFSR mode, seeds 0xACE1 ^ ch.
        bus.i_mode = 2'd3;
        bus.i_div  = 16'd0;
        step();
        chk("lfsr_first", 64'(bus.o_data), 64'(pack4('h2CE1, 'h2CE0, 'h2CE3, 'h2CE2)));
        step();
        chk("lfsr_second_ch0", 64'(ch0()), 64'h19C3);
        for (int c = 0; c < 4; c++) begin
            ref_st[c] = 16'hACE1 ^ 16'(c);
            for (int k = 0; k < 2; k++) begin
                ref_st[c] = {ref_st[c][14:0],
                             ref_st[c][15] ^ ref_st[c][13] ^ ref_st[c][12] ^ ref_st[c][10]};
            end
        end
        for (int n = 0; n < 1000; n++) begin
            step();
            exp_w = {ref_st[3][13:0], ref_st[2][13:0], ref_st[1][13:0], ref_st[0][13:0]};
            chk("lfsr_model", 64'(bus.o_data), 64'(exp_w));
            for (int c = 0; c < 4; c++) begin
                ref_st[c] = {ref_st[c][14:0],
                             ref_st[c][15] ^ ref_st[c][13] ^ ref_st[c][12] ^ ref_st[c][10]};
            end
        end

        // Triangle on the 4-bit instance: 0..15, 14..0, 1.
        bus4.i_en = 1'b1;
        step();
        chk("tri_idle_valid", 64'(bus4.o_valid), 64'd0);
        for (int j = 0; j < 32; j++) begin
            step();
            tv = (j <= 15) ? j : ((j <= 30) ? 30 - j : j - 30);
            chk("tri_valid", 64'(bus4.o_valid), 64'd1);
            chk("tri_sample", 64'(bus4.o_data), 64'(tv));
        end

        // Reset mid-run.
        i_rst = 1'b0;
        bus.i_mode = 2'd1;
        step();
        chk("midrst_data", 64'(bus.o_data), 64'd0);
        chk("midrst_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_data4", 64'(bus4.o_data), 64'd0);

        // Restart ramp and run to the 14-bit wrap.
        i_rst = 1'b1;
        step();
        step();
        chk("rst2_edge2_valid", 64'(bus.o_valid), 64'd0);
        step();
        chk("rst2_first", 64'(bus.o_data), 64'(pack4(0, 1, 2, 3)));
        for (int k = 0; k < 16383; k++) begin
            step();
        end
        chk("wrap_top_valid", 64'(bus.o_valid), 64'd1);
        chk("wrap_top", 64'(bus.o_data), 64'(pack4(16383, 0, 1, 2)));
        step();
        chk("wrap_zero", 64'(bus.o_data), 64'(pack4(0, 1, 2, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
